// File: rtl/arm_regs_pkg.sv
// Shared definitions for the banked ARM register file: register indices, mode
// encodings, CPSR layout, SPSR slots and the (mode, index) -> storage mapping.
package arm_regs_pkg;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam logic [31:0] CPSR_RESET = 32'h0000_01D3;
  localparam int CPSR_N       = 31;
  localparam int CPSR_Z       = 30;
  localparam int CPSR_C       = 29;
  localparam int CPSR_V       = 28;
  localparam int CPSR_I       = 7;
  localparam int CPSR_F       = 6;
  localparam int CPSR_MODE_HI = 4;
  localparam int CPSR_MODE_LO = 0;

  // Physical register counts include the PC; the PC itself lives in its own flop.
  localparam int PHYS_REGS_BANKED = 31;
  localparam int PHYS_REGS_FLAT   = 16;
  localparam int GPR_SLOTS        = PHYS_REGS_BANKED - 1;
  localparam int SPSR_SLOTS       = 5;

  typedef enum logic [2:0] {
    SPSR_FIQ  = 3'd0,
    SPSR_IRQ  = 3'd1,
    SPSR_SVC  = 3'd2,
    SPSR_ABT  = 3'd3,
    SPSR_UND  = 3'd4,
    SPSR_NONE = 3'd7
  } spsr_slot_e;

  function automatic logic is_exc_mode(input logic [4:0] mode);
    return (mode == MODE_FIQ) || (mode == MODE_IRQ) || (mode == MODE_SVC) ||
           (mode == MODE_ABT) || (mode == MODE_UND);
  endfunction

  function automatic spsr_slot_e spsr_slot_of(input logic [4:0] mode);
    case (mode)
      MODE_FIQ: return SPSR_FIQ;
      MODE_IRQ: return SPSR_IRQ;
      MODE_SVC: return SPSR_SVC;
      MODE_ABT: return SPSR_ABT;
      MODE_UND: return SPSR_UND;
      default:  return SPSR_NONE;
    endcase
  endfunction

  // Layout: 0-14 USR, 15-21 FIQ r8-r14, then r13/r14 pairs for IRQ, SVC, ABT, UND.
  function automatic logic [4:0] phys_index(input logic [4:0] mode, input logic [3:0] idx,
                                            input logic banked);
    logic [4:0] base;
    base = {1'b0, idx};
    phys_index = base;
    if (banked && idx != REG_PC) begin
      case (mode)
        MODE_FIQ: if (idx >= 4'd8)   phys_index = base + 5'd7;
        MODE_IRQ: if (idx >= REG_SP) phys_index = base + 5'd9;
        MODE_SVC: if (idx >= REG_SP) phys_index = base + 5'd11;
        MODE_ABT: if (idx >= REG_SP) phys_index = base + 5'd13;
        MODE_UND: if (idx >= REG_SP) phys_index = base + 5'd15;
        default:  phys_index = base;
      endcase
    end
  endfunction

endpackage

// File: rtl/regfile_bank_map.sv
// Combinational bank map: (mode, architectural index) -> physical slot and SPSR slot.
module regfile_bank_map
  import arm_regs_pkg::*;
#(
  parameter bit BANKED = 1'b1
) (
  input  logic [4:0]  mode,
  input  logic [3:0]  arch_idx,
  output logic [4:0]  phys_idx,
  output spsr_slot_e  spsr_slot,
  output logic        spsr_valid
);

  always_comb begin
    phys_idx   = phys_index(mode, arch_idx, BANKED);
    spsr_slot  = spsr_slot_of(mode);
    spsr_valid = BANKED && (spsr_slot_of(mode) != SPSR_NONE);
  end

endmodule

// File: rtl/banked_register_file.sv
// ARM mode-banked register file with CPSR/SPSRs and single-cycle exception entry.
// Optional same-cycle write forwarding to the read ports: define REGFILE_BYPASS_EN.
module banked_register_file
  import arm_regs_pkg::*;
#(
  parameter int          NREAD        = 3,
  parameter bit          BANKED       = 1'b1,
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*NREAD-1:0]    rd_addr,
  output logic [32*NREAD-1:0]   rd_data,
  output logic [31:0]           pc_out,
  output logic [31:0]           cpsr_out,
  output logic [3:0]            flags_out,
  output logic [31:0]           spsr_out,
  input  logic                  wb_en,
  input  logic [3:0]            wb_addr,
  input  logic [31:0]           wb_data,
  input  logic                  pc_inc_en,
  input  logic [31:0]           pc_next,
  input  logic                  flags_we,
  input  logic [3:0]            flags_in,
  input  logic                  cpsr_we,
  input  logic [31:0]           cpsr_in,
  input  logic                  restore_en,
  input  logic                  exc_en,
  input  logic [4:0]            exc_mode,
  input  logic [31:0]           exc_vector
);

  logic [31:0] gpr_q  [GPR_SLOTS];
  logic [31:0] gpr_d  [GPR_SLOTS];
  logic [31:0] spsr_q [SPSR_SLOTS];
  logic [31:0] spsr_d [SPSR_SLOTS];
  logic [31:0] pc_q, pc_d;
  logic [31:0] cpsr_q, cpsr_d;

  logic [4:0]  cur_mode;
  logic [4:0]  wr_phys;
  spsr_slot_e  cur_slot;
  logic        cur_spsr_valid;
  logic        exc_accept;
  logic [4:0]  exc_lr_phys;
  spsr_slot_e  exc_slot;
  logic        wb_pc;

  assign cur_mode = cpsr_q[CPSR_MODE_HI:CPSR_MODE_LO];

  // Write port map also yields the current mode's SPSR slot for restore and spsr_out.
  regfile_bank_map #(.BANKED(BANKED)) u_wr_map (
    .mode       (cur_mode),
    .arch_idx   (wb_addr),
    .phys_idx   (wr_phys),
    .spsr_slot  (cur_slot),
    .spsr_valid (cur_spsr_valid)
  );

  assign exc_accept  = exc_en && (!BANKED || is_exc_mode(exc_mode));
  assign exc_lr_phys = phys_index(exc_mode, REG_LR, BANKED);
  assign exc_slot    = spsr_slot_of(exc_mode);
  assign wb_pc       = wb_en && (wb_addr == REG_PC);

  always_comb begin
    gpr_d  = gpr_q;
    spsr_d = spsr_q;
    pc_d   = pc_q;
    cpsr_d = cpsr_q;
    if (exc_accept) begin
      pc_d = exc_vector;
      cpsr_d[CPSR_MODE_HI:CPSR_MODE_LO] = exc_mode;
      cpsr_d[CPSR_I] = 1'b1;
      if (exc_mode == MODE_FIQ) cpsr_d[CPSR_F] = 1'b1;
      if (BANKED) begin
        spsr_d[exc_slot]   = cpsr_q;
        gpr_d[exc_lr_phys] = pc_next;
      end
    end else begin
      if (wb_pc) begin
        pc_d = wb_data;
      end else begin
        if (wb_en)     gpr_d[wr_phys] = wb_data;
        if (pc_inc_en) pc_d = pc_next;
      end
      // A restore with no SPSR in this mode falls through to the other CPSR writes.
      if (restore_en && cur_spsr_valid) begin
        cpsr_d = spsr_q[cur_slot];
      end else if (cpsr_we) begin
        cpsr_d = cpsr_in;
      end else if (flags_we) begin
        cpsr_d[CPSR_N:CPSR_V] = flags_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GPR_SLOTS; i++) gpr_q[i] <= '0;
      for (int i = 0; i < SPSR_SLOTS; i++) spsr_q[i] <= '0;
      pc_q   <= RESET_VECTOR;
      cpsr_q <= CPSR_RESET;
    end else begin
      gpr_q  <= gpr_d;
      spsr_q <= spsr_d;
      pc_q   <= pc_d;
      cpsr_q <= cpsr_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [3:0]  addr;
    logic [4:0]  phys;
    logic [31:0] data;
    spsr_slot_e  slot_unused;
    logic        valid_unused;

    assign addr = rd_addr[4*i +: 4];

    regfile_bank_map #(.BANKED(BANKED)) u_rd_map (
      .mode       (cur_mode),
      .arch_idx   (addr),
      .phys_idx   (phys),
      .spsr_slot  (slot_unused),
      .spsr_valid (valid_unused)
    );

    always_comb begin
      if (addr == REG_PC) data = pc_q;
      else                data = gpr_q[phys];
`ifdef REGFILE_BYPASS_EN
      // Reads and writes share the current mode, so equal physical slots mean same bank.
      if (addr == REG_PC) begin
        if (wb_pc && !exc_en)               data = wb_data;
        else if (pc_inc_en && !wb_pc && !exc_en) data = pc_next;
      end else if (wb_en && !exc_en && !wb_pc && (phys == wr_phys)) begin
        data = wb_data;
      end
`endif
    end

    assign rd_data[32*i +: 32] = data;
  end

  assign pc_out    = pc_q;
  assign cpsr_out  = cpsr_q;
  assign flags_out = cpsr_q[CPSR_N:CPSR_V];
  assign spsr_out  = cur_spsr_valid ? spsr_q[cur_slot] : 32'h0;

endmodule

// File: tb/tb_banked_register_file.sv
// Scoreboard bench for banked_register_file: directed test-plan sequences plus
// random traffic, checked against a per-mode register model.
module tb_banked_register_file;

  localparam int          NREAD = 3;
  localparam logic [31:0] RV    = 32'h0000_0040;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [4*NREAD-1:0]  rd_addr = '0;
  logic [32*NREAD-1:0] rd_data;
  logic [31:0]         pc_out, cpsr_out, spsr_out;
  logic [3:0]          flags_out;
  logic                wb_en = 0, pc_inc_en = 0, flags_we = 0, cpsr_we = 0;
  logic                restore_en = 0, exc_en = 0;
  logic [3:0]          wb_addr = '0, flags_in = '0;
  logic [31:0]         wb_data = '0, pc_next = '0, cpsr_in = '0, exc_vector = '0;
  logic [4:0]          exc_mode = '0;

  banked_register_file #(.NREAD(NREAD), .BANKED(1'b1), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .pc_out(pc_out), .cpsr_out(cpsr_out), .flags_out(flags_out), .spsr_out(spsr_out),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_inc_en(pc_inc_en), .pc_next(pc_next),
    .flags_we(flags_we), .flags_in(flags_in),
    .cpsr_we(cpsr_we), .cpsr_in(cpsr_in), .restore_en(restore_en),
    .exc_en(exc_en), .exc_mode(exc_mode), .exc_vector(exc_vector)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        pc_inc_en;
    logic [31:0] pc_next;
    logic        flags_we;
    logic [3:0]  flags_in;
    logic        cpsr_we;
    logic [31:0] cpsr_in;
    logic        restore_en;
    logic        exc_en;
    logic [4:0]  exc_mode;
    logic [31:0] exc_vector;
    logic [11:0] rd_addr;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cpsr;
    logic [31:0] spsr;
    logic [31:0] rd [NREAD];
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: USR registers, FIQ r8-r14, r13/r14 for IRQ/SVC/ABT/UND, SPSRs.
  logic [31:0] m_usr  [15];
  logic [31:0] m_fiq  [7];
  logic [31:0] m_bk   [4][2];
  logic [31:0] m_spsr [5];
  logic [31:0] m_pc, m_cpsr;

  logic [4:0] modes [8] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011,
                            5'b10111, 5'b11011, 5'b11111, 5'b10100};

  // 0 = user registers only, 1 = FIQ, 2..5 = IRQ/SVC/ABT/UND
  function automatic int bank_of(input logic [4:0] m);
    case (m)
      5'b10001: return 1;
      5'b10010: return 2;
      5'b10011: return 3;
      5'b10111: return 4;
      5'b11011: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] m, input logic [3:0] a);
    int b = bank_of(m);
    int ai = int'(a);
    if (ai == 15) return m_pc;
    if (b == 1 && ai >= 8) return m_fiq[ai-8];
    if (b >= 2 && ai >= 13) return m_bk[b-2][ai-13];
    return m_usr[ai];
  endfunction

  task automatic m_write(input logic [4:0] m, input logic [3:0] a, input logic [31:0] d);
    int b = bank_of(m);
    int ai = int'(a);
    if (b == 1 && ai >= 8) m_fiq[ai-8] = d;
    else if (b >= 2 && ai >= 13) m_bk[b-2][ai-13] = d;
    else m_usr[ai] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_usr[i] = '0;
    for (int i = 0; i < 7; i++) m_fiq[i] = '0;
    for (int i = 0; i < 4; i++) begin m_bk[i][0] = '0; m_bk[i][1] = '0; end
    for (int i = 0; i < 5; i++) m_spsr[i] = '0;
    m_pc = RV;
    m_cpsr = 32'h0000_01D3;
  endtask

  task automatic model_step(input stim_t s);
    logic [4:0] m = m_cpsr[4:0];
    int eb = bank_of(s.exc_mode);
    int cb = bank_of(m);
    if (s.exc_en && eb != 0) begin
      m_spsr[eb-1] = m_cpsr;
      m_write(s.exc_mode, 4'd14, s.pc_next);
      m_pc = s.exc_vector;
      m_cpsr[4:0] = s.exc_mode;
      m_cpsr[7] = 1'b1;
      if (eb == 1) m_cpsr[6] = 1'b1;
    end else begin
      if (s.wb_en && s.wb_addr == 4'd15) m_pc = s.wb_data;
      else begin
        if (s.wb_en) m_write(m, s.wb_addr, s.wb_data);
        if (s.pc_inc_en) m_pc = s.pc_next;
      end
      if (s.restore_en && cb != 0) m_cpsr = m_spsr[cb-1];
      else if (s.cpsr_we) m_cpsr = s.cpsr_in;
      else if (s.flags_we) m_cpsr[31:28] = s.flags_in;
    end
  endtask

  function automatic stim_t idle(input logic [11:0] ra);
    stim_t s;
    s = '{default: '0};
    s.rd_addr = ra;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    wb_en = s.wb_en; wb_addr = s.wb_addr; wb_data = s.wb_data;
    pc_inc_en = s.pc_inc_en; pc_next = s.pc_next;
    flags_we = s.flags_we; flags_in = s.flags_in;
    cpsr_we = s.cpsr_we; cpsr_in = s.cpsr_in; restore_en = s.restore_en;
    exc_en = s.exc_en; exc_mode = s.exc_mode; exc_vector = s.exc_vector;
    rd_addr = s.rd_addr;
  endtask

  // One cycle: drive at the falling edge, queue the outputs expected before the next rise.
  task automatic issue(input stim_t s);
    exp_t e;
    int b;
    @(negedge clk);
    drive(s);
    b = bank_of(m_cpsr[4:0]);
    e.pc   = m_pc;
    e.cpsr = m_cpsr;
    e.spsr = (b != 0) ? m_spsr[b-1] : 32'h0;
    for (int i = 0; i < NREAD; i++) e.rd[i] = m_read(m_cpsr[4:0], s.rd_addr[4*i +: 4]);
    q.push_back(e);
    model_step(s);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc_out", pc_out, e.pc);
        check("cpsr_out", cpsr_out, e.cpsr);
        check("flags_out", {28'h0, flags_out}, {28'h0, e.cpsr[31:28]});
        check("spsr_out", spsr_out, e.spsr);
        for (int i = 0; i < NREAD; i++) check($sformatf("rd_data[%0d]", i), rd_data[32*i +: 32], e.rd[i]);
      end
    end
  end

  function automatic stim_t rand_stim();
    stim_t s;
    logic [31:0] r;
    s = '{default: '0};
    s.wb_en      = ($urandom_range(0, 1) == 1);
    s.wb_addr    = 4'($urandom_range(0, 15));
    s.wb_data    = $urandom();
    s.pc_inc_en  = ($urandom_range(0, 1) == 1);
    s.pc_next    = $urandom();
    s.flags_we   = ($urandom_range(0, 4) == 0);
    s.flags_in   = 4'($urandom_range(0, 15));
    s.cpsr_we    = ($urandom_range(0, 9) == 0);
    r            = $urandom();
    r[4:0]       = modes[$urandom_range(0, 7)];
    s.cpsr_in    = r;
    s.restore_en = ($urandom_range(0, 9) == 0);
    s.exc_en     = ($urandom_range(0, 11) == 0);
    s.exc_mode   = modes[$urandom_range(0, 7)];
    s.exc_vector = $urandom();
    s.rd_addr    = 12'($urandom());
    return s;
  endfunction

  initial begin : driver
    stim_t s;
    model_reset();
    repeat (2) @(negedge clk);
    rd_addr = {4'd14, 4'd13, 4'd0};
    rst_n = 1'b1;
    #1;
    check("reset pc_out", pc_out, RV);
    check("reset cpsr_out", cpsr_out, 32'h0000_01D3);
    check("reset flags_out", {28'h0, flags_out}, 32'h0);
    check("reset spsr_out", spsr_out, 32'h0);
    for (int i = 0; i < NREAD; i++) check("reset rd_data", rd_data[32*i +: 32], 32'h0);

    // SVC/USR banking of r13
    s = idle(12'hDDD); s.wb_en = 1; s.wb_addr = 4'd13; s.wb_data = 32'hAAAA; issue(s);
    s = idle(12'hDDD); s.cpsr_we = 1; s.cpsr_in = 32'h0000_0010; issue(s);
    s = idle(12'hDDD); s.wb_en = 1; s.wb_addr = 4'd13; s.wb_data = 32'h5555; issue(s);
    s = idle(12'hDDD); s.cpsr_we = 1; s.cpsr_in = 32'h0000_01D3; issue(s);
    issue(idle(12'hDDD));

    // IRQ entry from USR with a discarded write-back, then return
    s = idle(12'hE10); s.cpsr_we = 1; s.cpsr_in = 32'h0000_0010;
    s.wb_en = 1; s.wb_addr = 4'd15; s.wb_data = 32'h100; issue(s);
    s = idle(12'hE10); s.wb_en = 1; s.wb_addr = 4'd14; s.wb_data = 32'h7777; issue(s);
    s = idle(12'hE10); s.exc_en = 1; s.exc_mode = 5'b10010; s.exc_vector = 32'h18;
    s.pc_next = 32'h104; s.pc_inc_en = 1; s.wb_en = 1; s.wb_addr = 4'd1; s.wb_data = 32'hDEAD;
    s.cpsr_we = 1; s.cpsr_in = 32'h0000_001F; issue(s);
    s = idle(12'hE10); s.restore_en = 1; s.cpsr_we = 1; s.cpsr_in = 32'h0000_01D3; issue(s);
    issue(idle(12'hE10));
    // restore in USR is a no-op while cpsr_we still applies
    s = idle(12'hE10); s.restore_en = 1; s.cpsr_we = 1; s.cpsr_in = 32'h0000_01D3; issue(s);

    // write-back to PC beats the incrementer; cpsr_we beats flags_we
    s = idle(12'hF00); s.wb_en = 1; s.wb_addr = 4'd15; s.wb_data = 32'h200;
    s.pc_inc_en = 1; s.pc_next = 32'h108; issue(s);
    s = idle(12'hF00); s.flags_we = 1; s.flags_in = 4'b1000;
    s.cpsr_we = 1; s.cpsr_in = 32'h6000_01D3; issue(s);
    s = idle(12'hF00); s.flags_we = 1; s.flags_in = 4'b1001; issue(s);

    // read-during-write returns the old value
    s = idle(12'h333); s.wb_en = 1; s.wb_addr = 4'd3; s.wb_data = 32'h1234; issue(s);
    issue(idle(12'h333));

    repeat (1500) issue(rand_stim());

    // asynchronous reset mid-cycle with pending requests
    @(negedge clk);
    #3;
    s = rand_stim(); s.wb_en = 1; s.wb_addr = 4'd15; s.wb_data = 32'hBAD0; s.exc_en = 0;
    drive(s);
    rst_n = 1'b0;
    #1;
    check("async reset pc_out", pc_out, RV);
    check("async reset cpsr_out", cpsr_out, 32'h0000_01D3);
    @(posedge clk);
    #1;
    check("reset hold pc_out", pc_out, RV);
    @(negedge clk);
    drive(idle(12'h000));
    rst_n = 1'b1;
    model_reset();

    repeat (1500) issue(rand_stim());
    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
